// File: rtl/sc_bit_decider.sv
// Leaf decision unit of the SC polar decoder: hard decisions, partial sums, info-bit packing.
// Optional frozen-bit sign-violation counter enabled by defining DEC_ERR_CNT_EN.
module sc_bit_decider #(
    parameter int N_MAX  = 512,
    parameter int LLR_W  = 19,
    parameter int LOGN_W = 4,
    localparam int LOG2N = $clog2(N_MAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LOGN_W-1:0] n_log,
    input  logic              llr_valid,
    input  logic [LLR_W-1:0]  llr_in,
    input  logic              frozen,
    input  logic [3:0]        psum_stage,
    input  logic [LOG2N-1:0]  psum_base,
    input  logic [LOG2N-1:0]  psum_ofs,
    output logic              psum_bit,
    output logic              u_valid,
    output logic              u_hat,
    output logic [LOG2N-1:0]  bit_idx,
    output logic              busy,
    output logic [N_MAX-1:0]  info_bits,
    output logic [LOG2N:0]    info_cnt,
    output logic              done,
    output logic [LOG2N:0]    err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [LOG2N-1:0] last_idx;
    logic [N_MAX-1:0] u_vec;
    logic             dec_en;
    logic             dec_u;
    logic             llr_neg;
    logic             unused_llr;

    assign llr_neg    = llr_in[LLR_W-1];
    assign unused_llr = ^llr_in[LLR_W-2:0];
    assign dec_en     = (state == RUN) && llr_valid && !start;
    assign dec_u      = !frozen && llr_neg;
    assign busy       = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = RUN;
        end else begin
            unique case (state)
                IDLE: state_nx = IDLE;
                RUN: begin
                    if (llr_valid && (bit_idx == last_idx)) begin
                        state_nx = DONE;
                    end
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // bit_idx parks on the last index so an L = N_MAX code never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_idx  <= '0;
            u_vec     <= '0;
            info_bits <= '0;
            info_cnt  <= '0;
            bit_idx   <= '0;
            u_valid   <= 1'b0;
            u_hat     <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            last_idx  <= LOG2N'((32'd1 << n_log) - 32'd1);
            u_vec     <= '0;
            info_bits <= '0;
            info_cnt  <= '0;
            bit_idx   <= '0;
            u_valid   <= 1'b0;
            u_hat     <= 1'b0;
            done      <= 1'b0;
        end else begin
            u_valid <= dec_en;
            done    <= (state == DONE);
            if (dec_en) begin
                u_hat          <= dec_u;
                u_vec[bit_idx] <= dec_u;
                if (bit_idx != last_idx) begin
                    bit_idx <= bit_idx + 1'b1;
                end
                if (!frozen && !info_cnt[LOG2N]) begin
                    info_bits[info_cnt[LOG2N-1:0]] <= dec_u;
                    info_cnt <= info_cnt + 1'b1;
                end
            end
        end
    end

`ifdef DEC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (start) begin
            err_cnt <= '0;
        end else if (dec_en && frozen && llr_neg && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

    // Column j of G_{2^s} selects every row index i that is a bit-superset of j.
    logic [N_MAX-1:0] psum_win;
    logic             psum_acc;
    int               psum_span;
    int               psum_j;
    int               psum_s;

    always_comb begin
        psum_win  = u_vec >> psum_base;
        psum_s    = (int'(psum_stage) > LOG2N) ? LOG2N : int'(psum_stage);
        psum_span = 1 << psum_s;
        psum_j    = int'(psum_ofs);
        psum_acc  = 1'b0;
        for (int i = 0; i < N_MAX; i++) begin
            if ((i < psum_span) && ((i & psum_j) == psum_j)) begin
                psum_acc = psum_acc ^ psum_win[i];
            end
        end
    end

    assign psum_bit = psum_acc;

endmodule

// File: tb/tb_sc_bit_decider.sv
// Scoreboard bench for sc_bit_decider: directed codewords, partial sums, restart and reset.
module tb_sc_bit_decider;

    localparam int N_MAX = 512;
    localparam int LLR_W = 19;
    localparam int LOGN_W = 4;
    localparam int LOG2N = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LOGN_W-1:0] n_log;
    logic              llr_valid;
    logic [LLR_W-1:0]  llr_in;
    logic              frozen;
    logic [3:0]        psum_stage;
    logic [LOG2N-1:0]  psum_base;
    logic [LOG2N-1:0]  psum_ofs;
    logic              psum_bit;
    logic              u_valid;
    logic              u_hat;
    logic [LOG2N-1:0]  bit_idx;
    logic              busy;
    logic [N_MAX-1:0]  info_bits;
    logic [LOG2N:0]    info_cnt;
    logic              done;
    logic [LOG2N:0]    err_cnt;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic exp_u[$];
    logic [N_MAX-1:0] exp_vec;
    int d0;

    sc_bit_decider dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_log(n_log),
        .llr_valid(llr_valid), .llr_in(llr_in), .frozen(frozen),
        .psum_stage(psum_stage), .psum_base(psum_base), .psum_ofs(psum_ofs),
        .psum_bit(psum_bit), .u_valid(u_valid), .u_hat(u_hat),
        .bit_idx(bit_idx), .busy(busy), .info_bits(info_bits),
        .info_cnt(info_cnt), .done(done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic e;
        if (done) done_seen++;
        if (u_valid) begin
            checks++;
            if (exp_u.size() == 0) begin
                errors++;
                $display("FAIL u_hat unexpected_u_valid act=%0d exp=none", u_hat);
            end else begin
                e = exp_u.pop_front();
                if (u_hat !== e) begin
                    errors++;
                    $display("FAIL u_hat act=%0d exp=%0d", u_hat, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic begin_cw(input int nl);
        start = 1'b1;
        n_log = 4'(nl);
        tick();
        start = 1'b0;
    endtask

    task automatic decide(input int v, input logic f, input logic e);
        llr_valid = 1'b1;
        llr_in = 19'(v);
        frozen = f;
        exp_u.push_back(e);
        tick();
        llr_valid = 1'b0;
        frozen = 1'b0;
    endtask

    task automatic psum_q(input string nm, input int s, input int b,
                          input int j, input int e);
        psum_stage = 4'(s);
        psum_base = 9'(b);
        psum_ofs = 9'(j);
        #1;
        chk(nm, longint'(psum_bit), e);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        n_log = '0;
        llr_valid = 1'b0;
        llr_in = '0;
        frozen = 1'b0;
        psum_stage = '0;
        psum_base = '0;
        psum_ofs = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_u_valid", u_valid, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_info_cnt", info_cnt, 0);
        chk("rst_info_zero", longint'(info_bits == '0), 1);
        chk("rst_done", done, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // L=4, all unfrozen
        begin_cw(2);
        chk("t1_busy", busy, 1);
        decide(-5, 1'b0, 1'b1);
        decide(3, 1'b0, 1'b0);
        decide(0, 1'b0, 1'b0);
        decide(-1, 1'b0, 1'b1);
        chk("t1_done_early", done, 0);
        tick();
        chk("t1_done", done, 1);
        tick();
        chk("t1_done_clear", done, 0);
        chk("t1_info_bits", longint'(info_bits[3:0]), 4'b1001);
        chk("t1_info_high_zero", longint'((info_bits >> 4) == '0), 1);
        chk("t1_info_cnt", info_cnt, 4);
        chk("t1_idle", busy, 0);

        // L=8, frozen = 8'b0001_0111, all LLR -7
        d0 = done_seen;
        begin_cw(3);
        for (int i = 0; i < 8; i++) begin
            logic f;
            f = ((8'b0001_0111 >> i) & 1) != 0;
            decide(-7, f, !f);
        end
        tick();
        tick();
        chk("t2_info_cnt", info_cnt, 4);
        chk("t2_info_bits", longint'(info_bits[3:0]), 4'b1111);
        chk("t2_done_pulses", done_seen - d0, 1);
`ifdef DEC_ERR_CNT_EN
        chk("t2_err_cnt", err_cnt, 4);
`else
        chk("t2_err_cnt", err_cnt, 0);
`endif

        // u = 0,0,0,1,0,1,1,1
        psum_q("t3_s2_j0", 2, 0, 0, 1);
        psum_q("t3_s2_j1", 2, 0, 1, 1);
        psum_q("t3_s2_j2", 2, 0, 2, 1);
        psum_q("t3_s2_j3", 2, 0, 3, 1);
        psum_q("t3_s1_b4_j0", 1, 4, 0, 1);
        psum_q("t3_s1_b4_j1", 1, 4, 1, 1);
        psum_q("t3_s0_b4", 0, 4, 0, 0);
        psum_q("t3_s0_b5", 0, 5, 0, 1);
        psum_q("t3_s2_b4_j0", 2, 4, 0, 1);
        psum_q("t3_s2_b4_j1", 2, 4, 1, 0);
        psum_q("t3_s3_j0", 3, 0, 0, 0);

        // frozen sign violations: three negative frozen LLRs
        begin_cw(3);
        chk("t6_err_cleared", err_cnt, 0);
        decide(-3, 1'b1, 1'b0);
        decide(-1, 1'b1, 1'b0);
        decide(-9, 1'b1, 1'b0);
        decide(4, 1'b1, 1'b0);
        decide(-2, 1'b0, 1'b1);
        decide(2, 1'b0, 1'b0);
        decide(0, 1'b1, 1'b0);
        decide(-6, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        chk("t6_info_cnt_hold", info_cnt, 3);
        chk("t6_info_bits", longint'(info_bits[2:0]), 3'b101);
`ifdef DEC_ERR_CNT_EN
        chk("t6_err_cnt", err_cnt, 3);
`else
        chk("t6_err_cnt", err_cnt, 0);
`endif

        // L = N_MAX, all unfrozen
        d0 = done_seen;
        exp_vec = '0;
        begin_cw(9);
        for (int i = 0; i < N_MAX; i++) begin
            int v;
            v = (i % 3 == 0) ? -(i + 1) : ((i % 3 == 1) ? 0 : i);
            exp_vec[i] = (i % 3 == 0);
            decide(v, 1'b0, (i % 3 == 0));
        end
        tick();
        tick();
        chk("tmax_info_cnt", info_cnt, N_MAX);
        chk("tmax_bit_idx_nowrap", bit_idx, N_MAX - 1);
        chk("tmax_done_pulses", done_seen - d0, 1);
        checks++;
        if (info_bits !== exp_vec) begin
            errors++;
            $display("FAIL tmax_info_bits act=%h exp=%h", info_bits, exp_vec);
        end

        // restart mid-codeword with a coincident LLR
        begin_cw(3);
        decide(-2, 1'b0, 1'b1);
        decide(2, 1'b0, 1'b0);
        decide(-2, 1'b0, 1'b1);
        decide(2, 1'b0, 1'b0);
        decide(-2, 1'b0, 1'b1);
        chk("t4_bit_idx_pre", bit_idx, 5);
        d0 = done_seen;
        start = 1'b1;
        n_log = 4'd3;
        llr_valid = 1'b1;
        llr_in = 19'(-8);
        tick();
        start = 1'b0;
        llr_valid = 1'b0;
        chk("t4_bit_idx", bit_idx, 0);
        chk("t4_info_cnt", info_cnt, 0);
        chk("t4_busy", busy, 1);
        chk("t4_u_valid", u_valid, 0);
        tick();
        tick();
        tick();
        chk("t4_no_done", done_seen - d0, 0);

        // reset mid-codeword
        decide(-4, 1'b0, 1'b1);
        decide(4, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", busy, 0);
        chk("t5_bit_idx", bit_idx, 0);
        chk("t5_info_cnt", info_cnt, 0);
        chk("t5_info_zero", longint'(info_bits == '0), 1);
        chk("t5_u_valid", u_valid, 0);
        chk("t5_done", done, 0);
        llr_valid = 1'b1;
        llr_in = 19'(-3);
        tick();
        tick();
        llr_valid = 1'b0;
        chk("t5_ignored_idx", bit_idx, 0);
        chk("t5_ignored_uv", u_valid, 0);
        chk("t5_ignored_cnt", info_cnt, 0);
        tick();
        chk("scoreboard_drained", exp_u.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
